// File: rtl/warp_fetch_sched.sv
// Per-warp fetch scheduler: round-robin pick of one eligible warp per cycle,
// presented as a registered fetch request with one fetch outstanding per warp.
module warp_fetch_sched #(
    parameter  int NUM_WARPS   = 4,
    parameter  int NUM_THREADS = 4,
    parameter  int PC_BITS     = 31,
    parameter  int UUID_WIDTH  = 44,
    localparam int NW_WIDTH    = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
) (
    input  logic                   clk,
    input  logic                   reset,

    input  logic                   start_valid,
    input  logic [NW_WIDTH-1:0]    start_wid,
    input  logic [PC_BITS-1:0]     start_PC,
    input  logic [NUM_THREADS-1:0] start_tmask,

    input  logic                   redirect_valid,
    input  logic [NW_WIDTH-1:0]    redirect_wid,
    input  logic [PC_BITS-1:0]     redirect_PC,
    input  logic [NUM_THREADS-1:0] redirect_tmask,

    input  logic                   done_valid,
    input  logic [NW_WIDTH-1:0]    done_wid,

    output logic                   sched_valid,
    input  logic                   sched_ready,
    output logic [NW_WIDTH-1:0]    sched_wid,
    output logic [PC_BITS-1:0]     sched_PC,
    output logic [NUM_THREADS-1:0] sched_tmask,
    output logic [UUID_WIDTH-1:0]  sched_uuid,

    output logic [NUM_WARPS-1:0]   active_warps,
    output logic                   busy
);

    logic [NUM_WARPS-1:0]                   active_q, active_d;
    logic [NUM_WARPS-1:0]                   stalled_q, stalled_d;
    logic [NUM_WARPS-1:0][PC_BITS-1:0]      pc_q, pc_d;
    logic [NUM_WARPS-1:0][NUM_THREADS-1:0]  tmask_q, tmask_d;
    logic [NW_WIDTH-1:0]                    rr_ptr_q;
    logic [UUID_WIDTH-1:0]                  uuid_q;

    logic                   valid_q;
    logic [NW_WIDTH-1:0]    wid_q;
    logic [PC_BITS-1:0]     spc_q;
    logic [NUM_THREADS-1:0] stmask_q;
    logic [UUID_WIDTH-1:0]  suuid_q;

    logic [NUM_WARPS-1:0] eligible;
    logic                 ld;
    logic                 grant_found;
    logic [NW_WIDTH-1:0]  grant_wid;
    logic [NW_WIDTH-1:0]  cand;
    logic                 grant_fire;

    logic [NUM_WARPS-1:0] is_redir;
    logic [NUM_WARPS-1:0] is_start;
    logic [NUM_WARPS-1:0] is_done;
    logic [NUM_WARPS-1:0] is_grant;

    assign eligible   = active_q & ~stalled_q;
    assign ld         = ~valid_q | sched_ready;
    assign grant_fire = ld & grant_found;

    // Search starts one past the last grant; power-of-two count makes the wrap free.
    always_comb begin
        grant_found = 1'b0;
        grant_wid   = '0;
        cand        = '0;
        for (int i = 1; i <= NUM_WARPS; i++) begin
            cand = rr_ptr_q + NW_WIDTH'(i);
            if (!grant_found && eligible[cand]) begin
                grant_found = 1'b1;
                grant_wid   = cand;
            end
        end
    end

    always_comb begin
        is_redir = '0;
        is_start = '0;
        is_done  = '0;
        is_grant = '0;
        for (int w = 0; w < NUM_WARPS; w++) begin
            is_redir[w] = redirect_valid && (redirect_wid == NW_WIDTH'(w));
            is_start[w] = start_valid && (start_wid == NW_WIDTH'(w))
                          && !active_q[w] && !is_redir[w];
            is_done[w]  = done_valid && (done_wid == NW_WIDTH'(w));
            is_grant[w] = grant_fire && (grant_wid == NW_WIDTH'(w));
        end
    end

    // Later assignments override earlier ones: redirect > start > grant increment.
    always_comb begin
        active_d  = active_q;
        stalled_d = stalled_q;
        pc_d      = pc_q;
        tmask_d   = tmask_q;
        for (int w = 0; w < NUM_WARPS; w++) begin
            if (is_grant[w]) begin
                pc_d[w] = pc_q[w] + PC_BITS'(2);
            end
            if (is_start[w]) begin
                active_d[w] = 1'b1;
                pc_d[w]     = start_PC;
                tmask_d[w]  = start_tmask;
            end
            if (is_redir[w]) begin
                pc_d[w]    = redirect_PC;
                tmask_d[w] = redirect_tmask;
                if (redirect_tmask == '0) begin
                    active_d[w] = 1'b0;
                end
            end
            if (is_start[w] || is_done[w]) begin
                stalled_d[w] = 1'b0;
            end
            if (is_grant[w]) begin
                stalled_d[w] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            active_q  <= '0;
            stalled_q <= '0;
            pc_q      <= '0;
            tmask_q   <= '0;
        end else begin
            active_q  <= active_d;
            stalled_q <= stalled_d;
            pc_q      <= pc_d;
            tmask_q   <= tmask_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr_q <= NW_WIDTH'(NUM_WARPS - 1);
            uuid_q   <= '0;
            valid_q  <= 1'b0;
            wid_q    <= '0;
            spc_q    <= '0;
            stmask_q <= '0;
            suuid_q  <= '0;
        end else if (ld) begin
            valid_q <= grant_found;
            if (grant_found) begin
                rr_ptr_q <= grant_wid;
                uuid_q   <= uuid_q + UUID_WIDTH'(1);
                wid_q    <= grant_wid;
                spc_q    <= pc_q[grant_wid];
                stmask_q <= tmask_q[grant_wid];
                suuid_q  <= uuid_q;
            end
        end
    end

    assign sched_valid  = valid_q;
    assign sched_wid    = wid_q;
    assign sched_PC     = spc_q;
    assign sched_tmask  = stmask_q;
    assign sched_uuid   = suuid_q;
    assign active_warps = active_q;
    assign busy         = (|active_q) | valid_q;

endmodule

// File: tb/tb_warp_fetch_sched.sv
// Directed bench for warp_fetch_sched: per-cycle vector table plus
// hand-written reset sequences.
module tb_warp_fetch_sched;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_valid;
    logic [1:0]  start_wid;
    logic [30:0] start_PC;
    logic [3:0]  start_tmask;
    logic        redirect_valid;
    logic [1:0]  redirect_wid;
    logic [30:0] redirect_PC;
    logic [3:0]  redirect_tmask;
    logic        done_valid;
    logic [1:0]  done_wid;
    logic        sched_valid;
    logic        sched_ready;
    logic [1:0]  sched_wid;
    logic [30:0] sched_PC;
    logic [3:0]  sched_tmask;
    logic [43:0] sched_uuid;
    logic [3:0]  active_warps;
    logic        busy;

    int checks = 0;
    int errors = 0;

    warp_fetch_sched dut (
        .clk            (clk),
        .reset          (reset),
        .start_valid    (start_valid),
        .start_wid      (start_wid),
        .start_PC       (start_PC),
        .start_tmask    (start_tmask),
        .redirect_valid (redirect_valid),
        .redirect_wid   (redirect_wid),
        .redirect_PC    (redirect_PC),
        .redirect_tmask (redirect_tmask),
        .done_valid     (done_valid),
        .done_wid       (done_wid),
        .sched_valid    (sched_valid),
        .sched_ready    (sched_ready),
        .sched_wid      (sched_wid),
        .sched_PC       (sched_PC),
        .sched_tmask    (sched_tmask),
        .sched_uuid     (sched_uuid),
        .active_warps   (active_warps),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        sv;
        logic [1:0]  sw;
        logic [30:0] spc;
        logic [3:0]  stm;
        logic        rv;
        logic [1:0]  rw;
        logic [30:0] rpc;
        logic [3:0]  rtm;
        logic        dv;
        logic [1:0]  dw;
        logic        rdy;
        logic        ev;
        logic [1:0]  ew;
        logic [30:0] epc;
        logic [3:0]  etm;
        logic [43:0] eu;
        logic [3:0]  eact;
        logic        ebusy;
    } vec_t;

    vec_t vq[$];

    task automatic add(
        input logic sv, input logic [1:0] sw,
        input logic [30:0] spc, input logic [3:0] stm,
        input logic rv, input logic [1:0] rw,
        input logic [30:0] rpc, input logic [3:0] rtm,
        input logic dv, input logic [1:0] dw, input logic rdy,
        input logic ev, input logic [1:0] ew,
        input logic [30:0] epc, input logic [3:0] etm,
        input logic [43:0] eu, input logic [3:0] eact,
        input logic ebusy);
        vec_t v;
        v.sv = sv;   v.sw = sw;   v.spc = spc; v.stm = stm;
        v.rv = rv;   v.rw = rw;   v.rpc = rpc; v.rtm = rtm;
        v.dv = dv;   v.dw = dw;   v.rdy = rdy;
        v.ev = ev;   v.ew = ew;   v.epc = epc; v.etm = etm;
        v.eu = eu;   v.eact = eact; v.ebusy = ebusy;
        vq.push_back(v);
    endtask

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        start_valid    = 1'b0;
        start_wid      = '0;
        start_PC       = '0;
        start_tmask    = '0;
        redirect_valid = 1'b0;
        redirect_wid   = '0;
        redirect_PC    = '0;
        redirect_tmask = '0;
        done_valid     = 1'b0;
        done_wid       = '0;
    endtask

    initial begin
        // start / redirect / done / ready  ->  valid wid PC tmask uuid active busy
        add(1,0,31'h40,4'hF, 0,0,0,0, 0,0, 1,  0,0,0,0,0,      4'b0001,1); // 0
        add(0,0,0,0,         0,0,0,0, 0,0, 1,  1,0,31'h40,4'hF,0, 4'b0001,1);
        add(0,0,0,0,         0,0,0,0, 0,0, 1,  0,0,0,0,0,      4'b0001,1);
        add(0,0,0,0,         0,0,0,0, 1,0, 1,  0,0,0,0,0,      4'b0001,1);
        add(0,0,0,0,         0,0,0,0, 0,0, 1,  1,0,31'h42,4'hF,1, 4'b0001,1);
        add(0,0,0,0,         0,0,0,0, 0,0, 1,  0,0,0,0,0,      4'b0001,1); // 5
        add(1,1,31'h80,4'h3, 0,0,0,0, 1,0, 1,  0,0,0,0,0,      4'b0011,1);
        add(1,2,31'h200,4'h5,0,0,0,0, 0,0, 1,  1,1,31'h80,4'h3,2, 4'b0111,1);
        add(1,3,31'h300,4'h8,0,0,0,0, 1,1, 1,  1,2,31'h200,4'h5,3,4'b1111,1);
        add(0,0,0,0,         0,0,0,0, 1,2, 1,  1,3,31'h300,4'h8,4,4'b1111,1);
        add(0,0,0,0,         0,0,0,0, 1,3, 1,  1,0,31'h44,4'hF,5, 4'b1111,1); // 10
        add(0,0,0,0,         0,0,0,0, 1,0, 1,  1,1,31'h82,4'h3,6, 4'b1111,1);
        add(0,0,0,0,         0,0,0,0, 1,1, 1,  1,2,31'h202,4'h5,7,4'b1111,1);
        add(0,0,0,0,         0,0,0,0, 0,0, 0,  1,2,31'h202,4'h5,7,4'b1111,1);
        add(1,0,31'h7FF,4'h1,0,0,0,0, 0,0, 0,  1,2,31'h202,4'h5,7,4'b1111,1);
        add(0,0,0,0,         0,0,0,0, 0,0, 0,  1,2,31'h202,4'h5,7,4'b1111,1); // 15
        add(0,0,0,0,         0,0,0,0, 0,0, 0,  1,2,31'h202,4'h5,7,4'b1111,1);
        add(0,0,0,0,         0,0,0,0, 0,0, 0,  1,2,31'h202,4'h5,7,4'b1111,1);
        add(0,0,0,0,         0,0,0,0, 0,0, 1,  1,3,31'h302,4'h8,8,4'b1111,1);
        add(0,0,0,0,         0,0,0,0, 0,0, 1,  1,0,31'h46,4'hF,9, 4'b1111,1);
        add(0,0,0,0, 1,1,31'h100,4'h3, 0,0, 1, 1,1,31'h84,4'h3,10,4'b1111,1); // 20
        add(0,0,0,0,         0,0,0,0, 1,1, 1,  0,0,0,0,0,      4'b1111,1);
        add(0,0,0,0,         0,0,0,0, 0,0, 1,  1,1,31'h100,4'h3,11,4'b1111,1);
        add(0,0,0,0,         1,1,0,0, 0,0, 1,  0,0,0,0,0,      4'b1101,1);
        add(0,0,0,0,         0,0,0,0, 1,1, 1,  0,0,0,0,0,      4'b1101,1);
        add(0,0,0,0,         0,0,0,0, 1,0, 1,  0,0,0,0,0,      4'b1101,1); // 25
        add(0,0,0,0,         0,0,0,0, 0,0, 1,  1,0,31'h48,4'hF,12,4'b1101,1);
        add(0,0,0,0,         0,0,0,0, 1,2, 1,  0,0,0,0,0,      4'b1101,1);
        add(0,0,0,0,         0,0,0,0, 0,0, 1,  1,2,31'h204,4'h5,13,4'b1101,1);
        add(0,0,0,0,         1,0,0,0, 0,0, 1,  0,0,0,0,0,      4'b1100,1);
        add(0,0,0,0,         1,2,0,0, 0,0, 1,  0,0,0,0,0,      4'b1000,1); // 30
        add(0,0,0,0,         1,3,0,0, 0,0, 1,  0,0,0,0,0,      4'b0000,0);

        idle_inputs();
        sched_ready = 1'b0;
        reset = 1'b1;
        #1;
        chk("rst_valid",  64'(sched_valid),  64'd0);
        chk("rst_wid",    64'(sched_wid),    64'd0);
        chk("rst_pc",     64'(sched_PC),     64'd0);
        chk("rst_tmask",  64'(sched_tmask),  64'd0);
        chk("rst_uuid",   64'(sched_uuid),   64'd0);
        chk("rst_active", 64'(active_warps), 64'd0);
        chk("rst_busy",   64'(busy),         64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        for (int k = 0; k < vq.size(); k++) begin
            @(negedge clk);
            start_valid    = vq[k].sv;
            start_wid      = vq[k].sw;
            start_PC       = vq[k].spc;
            start_tmask    = vq[k].stm;
            redirect_valid = vq[k].rv;
            redirect_wid   = vq[k].rw;
            redirect_PC    = vq[k].rpc;
            redirect_tmask = vq[k].rtm;
            done_valid     = vq[k].dv;
            done_wid       = vq[k].dw;
            sched_ready    = vq[k].rdy;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_valid", k), 64'(sched_valid), 64'(vq[k].ev));
            chk($sformatf("v%0d_active", k), 64'(active_warps),
                64'(vq[k].eact));
            chk($sformatf("v%0d_busy", k), 64'(busy), 64'(vq[k].ebusy));
            if (vq[k].ev) begin
                chk($sformatf("v%0d_wid", k), 64'(sched_wid), 64'(vq[k].ew));
                chk($sformatf("v%0d_pc", k), 64'(sched_PC), 64'(vq[k].epc));
                chk($sformatf("v%0d_tmask", k), 64'(sched_tmask),
                    64'(vq[k].etm));
                chk($sformatf("v%0d_uuid", k), 64'(sched_uuid), 64'(vq[k].eu));
            end
        end

        // Reset while a request is pending must drop it immediately.
        @(negedge clk);
        idle_inputs();
        sched_ready = 1'b0;
        start_valid = 1'b1;
        start_wid   = 2'd3;
        start_PC    = 31'h10;
        start_tmask = 4'h1;
        @(negedge clk);
        idle_inputs();
        @(posedge clk);
        #1;
        chk("pre_rst_valid", 64'(sched_valid), 64'd1);
        chk("pre_rst_wid",   64'(sched_wid),   64'd3);
        chk("pre_rst_uuid",  64'(sched_uuid),  64'd14);
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst_valid",  64'(sched_valid),  64'd0);
        chk("async_rst_active", 64'(active_warps), 64'd0);
        chk("async_rst_busy",   64'(busy),         64'd0);
        @(negedge clk);
        reset = 1'b0;
        sched_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            chk($sformatf("post_rst_idle%0d", c), 64'(sched_valid), 64'd0);
        end

        @(negedge clk);
        start_valid = 1'b1;
        start_wid   = 2'd1;
        start_PC    = 31'h20;
        start_tmask = 4'h2;
        @(negedge clk);
        idle_inputs();
        @(posedge clk);
        #1;
        chk("restart_valid", 64'(sched_valid), 64'd1);
        chk("restart_wid",   64'(sched_wid),   64'd1);
        chk("restart_pc",    64'(sched_PC),    64'h20);
        chk("restart_tmask", 64'(sched_tmask), 64'h2);
        chk("restart_uuid",  64'(sched_uuid),  64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
